// File: rtl/biriscv_mul_dispatch.sv
// Dispatch buffer in front of the multi-cycle multiplier: queues MUL ops, issues
// them one at a time as single-cycle pulses and exposes queued/in-flight rd for RAW checks.
module biriscv_mul_dispatch #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_pc_i,
    input  logic [4:0]  in_rd_idx_i,
    input  logic [31:0] in_ra_operand_i,
    input  logic [31:0] in_rb_operand_i,
    input  logic        flush_i,
    output logic        mul_valid_o,
    output logic [31:0] mul_pc_o,
    output logic [4:0]  mul_rd_idx_o,
    output logic [31:0] mul_ra_operand_o,
    output logic [31:0] mul_rb_operand_o,
    input  logic        mul_wb_valid_i,
    input  logic [4:0]  mul_wb_rd_idx_i,
    input  logic [4:0]  hzd_ra_idx_i,
    input  logic [4:0]  hzd_rb_idx_i,
    output logic        hazard_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t      state_q;
    logic [4:0]  inflight_rd_q;

    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic [PW:0]   fill_cnt;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    logic [31:0] pc_mem [DEPTH];
    logic [4:0]  rd_mem [DEPTH];
    logic [31:0] ra_mem [DEPTH];
    logic [31:0] rb_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic head_avail;
    logic pop;

    assign wr_idx   = wr_ptr_q[PW-1:0];
    assign rd_idx   = rd_ptr_q[PW-1:0];
    assign fill_cnt = wr_ptr_q - rd_ptr_q;

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);

    assign in_ready_o = !full;
    assign push       = in_valid_i && !full && !flush_i;
    assign head_avail = !empty && !flush_i;
    assign pop        = head_avail &&
                        ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && mul_wb_valid_i));

    assign busy_o = !empty || (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (flush_i)
                rd_ptr_q <= wr_ptr_q;
            else if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_idx] <= in_pc_i;
            rd_mem[wr_idx] <= in_rd_idx_i;
            ra_mem[wr_idx] <= in_ra_operand_i;
            rb_mem[wr_idx] <= in_rb_operand_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            inflight_rd_q    <= '0;
            mul_valid_o      <= 1'b0;
            mul_pc_o         <= '0;
            mul_rd_idx_o     <= '0;
            mul_ra_operand_o <= '0;
            mul_rb_operand_o <= '0;
            err_o            <= 1'b0;
        end else begin
            mul_valid_o <= 1'b0;

            // A writeback is legal only in WAIT and must name the in-flight rd.
            if (mul_wb_valid_i &&
                ((state_q != ST_WAIT) || (mul_wb_rd_idx_i != inflight_rd_q)))
                err_o <= 1'b1;

            if (pop) begin
                mul_valid_o      <= 1'b1;
                mul_pc_o         <= pc_mem[rd_idx];
                mul_rd_idx_o     <= rd_mem[rd_idx];
                mul_ra_operand_o <= ra_mem[rd_idx];
                mul_rb_operand_o <= rb_mem[rd_idx];
                inflight_rd_q    <= rd_mem[rd_idx];
            end

            case (state_q)
                ST_IDLE:  if (pop) state_q <= ST_ISSUE;
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (mul_wb_valid_i)
                        state_q <= pop ? ST_ISSUE : ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    logic [PW-1:0] slot_off [DEPTH];
    logic          fifo_hit;
    logic          inflight_hit;

    // Slot i is occupied when its distance from the read pointer is below the fill count.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = PW'(i) - rd_idx;
            if (({1'b0, slot_off[i]} < fill_cnt) && (rd_mem[i] != 5'd0) &&
                ((rd_mem[i] == hzd_ra_idx_i) || (rd_mem[i] == hzd_rb_idx_i)))
                fifo_hit = 1'b1;
        end
    end

    assign inflight_hit = (state_q != ST_IDLE) && (inflight_rd_q != 5'd0) &&
                          ((inflight_rd_q == hzd_ra_idx_i) || (inflight_rd_q == hzd_rb_idx_i));

    assign hazard_o = fifo_hit || inflight_hit;

endmodule
